// File: rtl/dlx_burst_mem_if.sv
// dlx_burst_mem_if: request/response bus of the DLX burst memory model.
//   ENABLE        request strobe (master -> memory)
//   READNOTWRITE  1 = read, 0 = write
//   ADDRESS       word address of the first beat
//   BURST_LEN     number of beats minus one
//   BYTE_EN       write byte mask, bit 0 selects DATA[0:7] (most significant byte)
//   DATA_IN       write data, one word per write beat
//   DATA_OUT      read data, non-zero only while DATA_READY
//   DATA_READY    one beat completes in this cycle
//   BUSY          memory is not idle
//   ERROR         out-of-range response, accompanies DATA_READY
interface dlx_burst_mem_if #(
    parameter int ADDRESS_SIZE = 16,
    parameter int WORD_SIZE    = 32,
    parameter int BURST_W      = 2
);
    logic                    ENABLE;
    logic                    READNOTWRITE;
    logic [ADDRESS_SIZE-1:0] ADDRESS;
    logic [BURST_W-1:0]      BURST_LEN;
    logic [0:WORD_SIZE/8-1]  BYTE_EN;
    logic [0:WORD_SIZE-1]    DATA_IN;
    logic [0:WORD_SIZE-1]    DATA_OUT;
    logic                    DATA_READY;
    logic                    BUSY;
    logic                    ERROR;

    modport master (
        output ENABLE, READNOTWRITE, ADDRESS, BURST_LEN, BYTE_EN, DATA_IN,
        input  DATA_OUT, DATA_READY, BUSY, ERROR
    );

    modport slave (
        input  ENABLE, READNOTWRITE, ADDRESS, BURST_LEN, BYTE_EN, DATA_IN,
        output DATA_OUT, DATA_READY, BUSY, ERROR
    );
endinterface

// File: rtl/dlx_burst_mem.sv
// dlx_burst_mem: single-port word memory model for DLX benches with a fixed
// access latency, byte-masked writes and wrapping (critical-word-first) bursts.
// One transaction is in flight at a time; requests arriving while busy are ignored.
// Ports:
//   clk   clock, all activity on the rising edge
//   rst   asynchronous reset, active high (array contents are kept)
//   bus   dlx_burst_mem_if slave modport (request, write data, registered response)
//
// state  | meaning
// S_IDLE | waiting for ENABLE, outputs low
// S_WAIT | latency countdown after acceptance
// S_BEAT | one data beat per cycle, DATA_READY high
// S_ERR  | single out-of-range response cycle, ERROR high
module dlx_burst_mem #(
    parameter int ADDRESS_SIZE = 16,
    parameter int WORD_SIZE    = 32,
    parameter int DEPTH        = 1024,
    parameter int LATENCY      = 2,
    parameter int MAX_BURST    = 4
) (
    input logic            clk,
    input logic            rst,
    dlx_burst_mem_if.slave bus
);
    localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int LAT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BYTES   = WORD_SIZE / 8;

    // Low address bits that rotate inside an aligned burst block.
    localparam logic [ADDRESS_SIZE-1:0] WRAP_MASK = ADDRESS_SIZE'(MAX_BURST - 1);
    localparam logic [LAT_W-1:0]        LAT_LOAD  = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_ERR} state_t;

    state_t                  state;
    logic                    rnw_q;
    logic [ADDRESS_SIZE-1:0] addr_q;
    logic [BURST_W-1:0]      len_q;
    logic [BURST_W-1:0]      beat_q;
    logic [0:BYTES-1]        be_q;
    logic [LAT_W-1:0]        lat_cnt;

    logic [0:WORD_SIZE-1]    mem [DEPTH];

    logic [MEM_AW-1:0]       cur_idx;
    logic [MEM_AW-1:0]       next_idx;
    logic                    mem_we;

    function automatic logic [ADDRESS_SIZE-1:0] beat_addr(
        input logic [ADDRESS_SIZE-1:0] base,
        input logic [BURST_W-1:0]      idx
    );
        return (base & ~WRAP_MASK) | ((base + ADDRESS_SIZE'(idx)) & WRAP_MASK);
    endfunction

    function automatic logic in_range(input logic [ADDRESS_SIZE-1:0] a);
        return 64'(a) < 64'(DEPTH);
    endfunction

    // Only in-range base addresses reach S_BEAT, so the low bits index the array.
    assign cur_idx  = MEM_AW'(beat_addr(addr_q, beat_q));
    assign next_idx = MEM_AW'(beat_addr(addr_q, beat_q + 1'b1));
    assign mem_we   = (state == S_BEAT) && !rnw_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            rnw_q          <= 1'b1;
            addr_q         <= '0;
            len_q          <= '0;
            beat_q         <= '0;
            be_q           <= '0;
            lat_cnt        <= '0;
            bus.DATA_OUT   <= '0;
            bus.DATA_READY <= 1'b0;
            bus.BUSY       <= 1'b0;
            bus.ERROR      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.ENABLE) begin
                        rnw_q    <= bus.READNOTWRITE;
                        addr_q   <= bus.ADDRESS;
                        len_q    <= bus.BURST_LEN;
                        be_q     <= bus.BYTE_EN;
                        beat_q   <= '0;
                        lat_cnt  <= LAT_LOAD;
                        bus.BUSY <= 1'b1;
                        if (LATENCY != 0) begin
                            state <= S_WAIT;
                        end else if (in_range(bus.ADDRESS)) begin
                            state          <= S_BEAT;
                            bus.DATA_READY <= 1'b1;
                            bus.DATA_OUT   <= bus.READNOTWRITE ?
                                              mem[MEM_AW'(bus.ADDRESS)] : '0;
                        end else begin
                            state          <= S_ERR;
                            bus.DATA_READY <= 1'b1;
                            bus.ERROR      <= 1'b1;
                            bus.DATA_OUT   <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == '0) begin
                        bus.DATA_READY <= 1'b1;
                        if (in_range(addr_q)) begin
                            state        <= S_BEAT;
                            bus.DATA_OUT <= rnw_q ? mem[cur_idx] : '0;
                        end else begin
                            state        <= S_ERR;
                            bus.ERROR    <= 1'b1;
                            bus.DATA_OUT <= '0;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                S_BEAT: begin
                    if (beat_q == len_q) begin
                        state          <= S_IDLE;
                        bus.DATA_READY <= 1'b0;
                        bus.BUSY       <= 1'b0;
                        bus.DATA_OUT   <= '0;
                    end else begin
                        beat_q       <= beat_q + 1'b1;
                        bus.DATA_OUT <= rnw_q ? mem[next_idx] : '0;
                    end
                end
                S_ERR: begin
                    state          <= S_IDLE;
                    bus.DATA_READY <= 1'b0;
                    bus.BUSY       <= 1'b0;
                    bus.ERROR      <= 1'b0;
                    bus.DATA_OUT   <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Array has no reset; a reset only stops further beats via the state register.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be_q[b]) begin
                    mem[cur_idx][8*b +: 8] <= bus.DATA_IN[8*b +: 8];
                end
            end
        end
    end
endmodule
